// File: rtl/ins_rom_loader_pkg.sv
// ins_rom_loader_pkg: shared widths, state encoding and byte-lane helper for the instruction memory loader
package ins_rom_loader_pkg;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_CNT_W = 10;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BEAT = 2'(BYTES_PER_WORD - 1);
    typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] b);
        return w[8*b +: 8];
    endfunction
endpackage

// File: rtl/ins_rom_loader.sv
// ins_rom_loader: streams 32-bit words into the byte-wide instruction memory, little-endian, holding the core meanwhile
module ins_rom_loader
    import ins_rom_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              core_hold,
    output logic              done,
    output logic              err_ovf,
    output logic [CNT_W-1:0]  words_written
);
    state_t            state;
    logic [31:0]       word;
    logic [1:0]        beat;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  remaining;

    assign core_hold = busy;

    // Loader FSM: every output is registered; ptr always points at the next byte to be written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            word <= '0;
            beat <= '0;
            ptr <= '0;
            remaining <= '0;
            s_ready <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err_ovf <= 1'b0;
            words_written <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        ptr <= {base_addr[ADDR_W-1:2], 2'b00};
                        remaining <= word_count;
                        err_ovf <= 1'b0;
                        words_written <= '0;
                        s_ready <= (word_count != '0);
                        state <= (word_count == '0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (s_valid) begin
                        word <= s_data;
                        beat <= '0;
                        s_ready <= 1'b0;
                        mem_we <= 1'b1;
                        mem_addr <= ptr;
                        mem_wdata <= s_data[7:0];
                        ptr <= ptr + ADDR_W'(1);
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (beat == LAST_BEAT) begin
                        mem_we <= 1'b0;
                        words_written <= words_written + CNT_W'(1);
                        remaining <= remaining - CNT_W'(1);
                        // ptr has already advanced past the last byte, so zero here means the memory end was crossed
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                        end else if (ptr == '0) begin
                            err_ovf <= 1'b1;
                            state <= DONE;
                        end else begin
                            s_ready <= 1'b1;
                            state <= WAIT;
                        end
                    end else begin
                        beat <= beat + 2'd1;
                        mem_addr <= ptr;
                        mem_wdata <= byte_of(word, beat + 2'd1);
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
